// File: rtl/rc_control_voltage.sv
// RC capacitor model feeding the 555 control pin: one exponential charge/discharge
// step per audio sample, Q16.16 accumulator, three-cycle update pipeline.
module rc_control_voltage #(
  parameter longint SAMPLE_RATE = 48000,
  parameter longint R_CHARGE    = 100000,
  parameter longint R_DISCHARGE = 100000,
  parameter longint C_PF        = 10000,
  parameter int     V_HIGH      = 16384,
  parameter int     V_LOW       = 0
) (
  input  logic               clk,
  input  logic               I_RSTn,
  input  logic               audio_clk_en,
  input  logic               gate,
  output logic signed [15:0] v_control,
  output logic               charging,
  output logic               settled
);

  function automatic logic [15:0] clamp_alpha(input longint raw);
    if (raw < 64'sd1) return 16'd1;
    else if (raw > 64'sd65535) return 16'hFFFF;
    else return 16'(raw);
  endfunction

  localparam longint ALPHA_NUM = 64'sd65536 * 64'sd1000000000000;
  localparam logic [15:0] ALPHA_CHARGE    = clamp_alpha(ALPHA_NUM / (R_CHARGE * C_PF * SAMPLE_RATE));
  localparam logic [15:0] ALPHA_DISCHARGE = clamp_alpha(ALPHA_NUM / (R_DISCHARGE * C_PF * SAMPLE_RATE));

  localparam logic signed [31:0] HIGH_Q   = V_HIGH * 65536;
  localparam logic signed [31:0] LOW_Q    = V_LOW * 65536;
  localparam logic signed [32:0] HIGH_Q33 = {HIGH_Q[31], HIGH_Q};
  localparam logic signed [32:0] LOW_Q33  = {LOW_Q[31], LOW_Q};

  localparam logic [1:0] IDLE_LOW    = 2'd0;
  localparam logic [1:0] CHARGING    = 2'd1;
  localparam logic [1:0] IDLE_HIGH   = 2'd2;
  localparam logic [1:0] DISCHARGING = 2'd3;

  logic signed [31:0] v_acc;
  logic [1:0]         state;
  logic               pending;
  logic               busy;
  logic               start;

  logic               s1_valid;
  logic               s1_gate;
  logic signed [31:0] s1_target;
  logic signed [31:0] s1_diff;
  logic [15:0]        s1_alpha;

  logic               s2_valid;
  logic               s2_gate;
  logic signed [31:0] s2_target;
  logic signed [31:0] s2_step;
  logic               s2_diff_nz;

  logic signed [31:0] target_sel;
  logic [15:0]        alpha_sel;
  logic signed [47:0] diff_ext;
  logic signed [47:0] alpha_ext;
  logic signed [47:0] product;
  logic signed [31:0] step_calc;
  logic signed [32:0] sum;
  logic signed [31:0] v_next;
  logic [1:0]         state_next;

  // Strobes are serialised: only one sample is in flight, so diff always sees the latest v_acc.
  always_comb begin
    busy       = s1_valid | s2_valid;
    start      = !busy && (audio_clk_en || pending);
    target_sel = gate ? HIGH_Q : LOW_Q;
    alpha_sel  = gate ? ALPHA_CHARGE : ALPHA_DISCHARGE;
  end

  always_comb begin
    diff_ext  = {{16{s1_diff[31]}}, s1_diff};
    alpha_ext = {32'd0, s1_alpha};
    product   = diff_ext * alpha_ext;
    step_calc = 32'(product >>> 16);
  end

  // A zero step with a nonzero distance would stall short of the rail, so snap to target.
  always_comb begin
    sum = {v_acc[31], v_acc} + {s2_step[31], s2_step};
    if (s2_step == 32'sd0 && s2_diff_nz) v_next = s2_target;
    else if (sum > HIGH_Q33)             v_next = HIGH_Q;
    else if (sum < LOW_Q33)              v_next = LOW_Q;
    else                                 v_next = sum[31:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE_LOW:    if (s2_gate) state_next = CHARGING;
      CHARGING:    if (!s2_gate) state_next = DISCHARGING;
                   else if (v_next == HIGH_Q) state_next = IDLE_HIGH;
      IDLE_HIGH:   if (!s2_gate) state_next = DISCHARGING;
      DISCHARGING: if (s2_gate) state_next = CHARGING;
                   else if (v_next == LOW_Q) state_next = IDLE_LOW;
      default:     state_next = IDLE_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      v_acc      <= LOW_Q;
      state      <= IDLE_LOW;
      pending    <= 1'b0;
      s1_valid   <= 1'b0;
      s1_gate    <= 1'b0;
      s1_target  <= '0;
      s1_diff    <= '0;
      s1_alpha   <= '0;
      s2_valid   <= 1'b0;
      s2_gate    <= 1'b0;
      s2_target  <= '0;
      s2_step    <= '0;
      s2_diff_nz <= 1'b0;
    end else begin
      pending  <= start ? 1'b0 : (pending | (audio_clk_en & busy));
      s1_valid <= start;
      if (start) begin
        s1_gate   <= gate;
        s1_target <= target_sel;
        s1_diff   <= target_sel - v_acc;
        s1_alpha  <= alpha_sel;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_gate    <= s1_gate;
        s2_target  <= s1_target;
        s2_step    <= step_calc;
        s2_diff_nz <= (s1_diff != 32'sd0);
      end
      if (s2_valid) begin
        v_acc <= v_next;
        state <= state_next;
      end
    end
  end

  assign v_control = v_acc[31:16];
  assign charging  = (state == CHARGING);
  assign settled   = (state == IDLE_LOW) || (state == IDLE_HIGH);

endmodule

// File: tb/tb_rc_control_voltage.sv
// Randomised bench for rc_control_voltage against a sample-level RC model with
// strobe scheduling, plus hand-computed anchor values.
module tb_rc_control_voltage;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               strobe;
  logic               gate;
  logic signed [15:0] v_control;
  logic               charging;
  logic               settled;

  rc_control_voltage dut (
    .clk          (clk),
    .I_RSTn       (rst_n),
    .audio_clk_en (strobe),
    .gate         (gate),
    .v_control    (v_control),
    .charging     (charging),
    .settled      (settled)
  );

  always #5 clk = ~clk;

  // 65536e12 / (100k * 10nF * 48 kHz) = 1365.33 -> 1365
  localparam longint ALPHA  = 1365;
  localparam longint HIGH_Q = 64'sd16384 * 64'sd65536;
  localparam longint LOW_Q  = 0;

  localparam int ST_IDLE_LOW    = 0;
  localparam int ST_CHARGING    = 1;
  localparam int ST_IDLE_HIGH   = 2;
  localparam int ST_DISCHARGING = 3;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     edge_cnt = 0;
  int     n_updates = 0;
  bit     check_en = 1'b0;

  longint m_v;
  int     m_state;
  int     free_at;
  bit     m_pend;
  bit     sched_valid;
  int     sched_edge;
  longint sched_v;
  int     sched_state;

  task automatic check_output(input string name, input longint actual, input longint expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One sample of the RC law, resolved immediately and made visible three edges later.
  task automatic launch(input bit g);
    longint tgt, d, st, nv;
    int ns;
    tgt = g ? HIGH_Q : LOW_Q;
    d   = tgt - m_v;
    st  = (d * ALPHA) >>> 16;
    if (st == 0 && d != 0) nv = tgt;
    else nv = m_v + st;
    if (nv > HIGH_Q) nv = HIGH_Q;
    if (nv < LOW_Q) nv = LOW_Q;
    ns = m_state;
    case (m_state)
      ST_IDLE_LOW:    if (g) ns = ST_CHARGING;
      ST_CHARGING:    if (!g) ns = ST_DISCHARGING; else if (nv == HIGH_Q) ns = ST_IDLE_HIGH;
      ST_IDLE_HIGH:   if (!g) ns = ST_DISCHARGING;
      default:        if (g) ns = ST_CHARGING; else if (nv == LOW_Q) ns = ST_IDLE_LOW;
    endcase
    sched_valid = 1'b1;
    sched_edge  = edge_cnt + 3;
    sched_v     = nv;
    sched_state = ns;
    free_at     = edge_cnt + 3;
  endtask

  task automatic model_reset();
    m_v         = LOW_Q;
    m_state     = ST_IDLE_LOW;
    m_pend      = 1'b0;
    sched_valid = 1'b0;
    free_at     = edge_cnt;
  endtask

  task automatic apply_stimulus(input bit s, input bit g);
    strobe = s;
    gate   = g;
    if (edge_cnt >= free_at) begin
      if (m_pend) begin
        launch(g);
        m_pend = 1'b0;
      end else if (s) begin
        launch(g);
      end
    end else if (s) begin
      m_pend = 1'b1;
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (sched_valid && sched_edge == edge_cnt) begin
      m_v         = sched_v;
      m_state     = sched_state;
      sched_valid = 1'b0;
      n_updates++;
    end
  endtask

  task automatic sample(input bit g);
    apply_stimulus(1'b1, g);
    apply_stimulus(1'b0, g);
    apply_stimulus(1'b0, g);
  endtask

  // Asynchronous pulse placed between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    strobe = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("reset_v_control", v_control, 0);
    check_output("reset_charging", charging, 0);
    check_output("reset_settled", settled, 1);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("v_control", v_control, m_v >>> 16);
      check_output("charging", charging, (m_state == ST_CHARGING) ? 1 : 0);
      check_output("settled", settled,
                   (m_state == ST_IDLE_LOW || m_state == ST_IDLE_HIGH) ? 1 : 0);
    end
  end

  initial begin
    int base;
    int guard;
    int v_before;
    bit g;
    rst_n  = 1'b0;
    strobe = 1'b0;
    gate   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_output("init_v_control", v_control, 0);
    check_output("init_settled", settled, 1);
    check_en = 1'b1;

    for (int i = 0; i < 10; i++) sample(1'b0);
    check_output("idle_low_v", v_control, 0);
    check_output("idle_low_settled", settled, 1);

    sample(1'b1);
    check_output("first_charge_v", v_control, 341);
    check_output("first_charge_charging", charging, 1);
    check_output("first_charge_settled", settled, 0);

    for (int i = 1; i < 48; i++) sample(1'b1);
    check_output("ramp48_in_band", (v_control >= 10401 && v_control <= 10433) ? 1 : 0, 1);

    guard = 0;
    while (!settled && guard < 2000) begin
      sample(1'b1);
      guard++;
    end
    check_output("charge_completes", (guard < 2000) ? 1 : 0, 1);
    check_output("charge_final_v", v_control, 16384);
    check_output("charge_final_charging", charging, 0);

    do_reset();
    for (int i = 0; i < 10; i++) sample(1'b1);
    v_before = v_control;
    sample(1'b0);
    check_output("reverse_goes_down", (v_control < v_before) ? 1 : 0, 1);
    check_output("reverse_charging", charging, 0);
    check_output("reverse_settled", settled, 0);
    guard = 0;
    while (!settled && guard < 3000) begin
      sample(1'b0);
      guard++;
    end
    check_output("discharge_completes", (guard < 3000) ? 1 : 0, 1);
    check_output("discharge_final_v", v_control, 0);

    do_reset();
    base = n_updates;
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);
    check_output("burst_two_steps_v", v_control, 675);
    check_output("burst_model_steps", n_updates - base, 2);

    do_reset();
    guard = 0;
    while (v_control < 8000 && guard < 300) begin
      sample(1'b1);
      guard++;
    end
    check_output("midcharge_reached", (guard < 300) ? 1 : 0, 1);
    do_reset();
    sample(1'b1);
    check_output("restart_after_reset_v", v_control, 341);

    g = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 149) == 0) g = ~g;
      if ($urandom_range(0, 1999) == 0) do_reset();
      apply_stimulus(($urandom_range(0, 3) == 0), g);
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
